// File: rtl/lab4_cmd_parser.sv
// lab4_cmd_parser: ASCII command parser for a UART-driven cipher front end.
// Commands: "L" + 8 hex digits + CR loads the seed, "E" + text + CR streams
// plaintext bytes, "D" + hex pairs + CR streams ciphertext bytes.
// Optional feature: define CMD_ECHO_EN to echo every received byte to tx_data.
module lab4_cmd_parser #(
  parameter int MSG_MAX = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  rx_data,
  input  logic        rx_data_rdy,
  output logic [31:0] seed,
  output logic        seed_ld,
  output logic [7:0]  pt_byte,
  output logic        pt_vld,
  output logic [7:0]  ct_byte,
  output logic        ct_vld,
  output logic        msg_start,
  output logic        msg_end,
  output logic [1:0]  mode,
  output logic        err,
  output logic [7:0]  tx_data,
  output logic        tx_data_rdy
);

  // One counter serves both the 0..8 key digit count and the payload count.
  localparam int CNT_W = ($clog2(MSG_MAX + 1) > 4) ? $clog2(MSG_MAX + 1) : 4;

  localparam logic [7:0] CH_CR = 8'h0D;
  localparam logic [7:0] CH_L  = 8'h4C;
  localparam logic [7:0] CH_E  = 8'h45;
  localparam logic [7:0] CH_D  = 8'h44;

  // State encoding doubles as the mode output.
  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_LOAD = 2'b01,
    ST_ENC  = 2'b10,
    ST_DEC  = 2'b11
  } state_t;

  state_t           r_state;
  logic [31:0]      r_shadow;
  logic [CNT_W-1:0] r_cnt;
  logic [3:0]       r_hi;
  logic             w_hex_ok;
  logic [3:0]       w_nib;

  // Returns {is_hex, nibble}; letters a-f/A-F share low bits, +9 maps them to 10..15.
  function automatic logic [4:0] hex_decode(input logic [7:0] c);
    logic [4:0] res;
    res = 5'b0;
    if (c >= 8'h30 && c <= 8'h39) begin
      res = {1'b1, c[3:0]};
    end else if ((c >= 8'h41 && c <= 8'h46) || (c >= 8'h61 && c <= 8'h66)) begin
      res = {1'b1, c[3:0] + 4'd9};
    end
    return res;
  endfunction

  assign {w_hex_ok, w_nib} = hex_decode(rx_data);
  assign mode = r_state;

  // Command FSM with registered outputs; pulses last one cycle after the causing byte.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_shadow  <= '0;
      r_cnt     <= '0;
      r_hi      <= '0;
      seed      <= '0;
      pt_byte   <= '0;
      ct_byte   <= '0;
      seed_ld   <= 1'b0;
      pt_vld    <= 1'b0;
      ct_vld    <= 1'b0;
      msg_start <= 1'b0;
      msg_end   <= 1'b0;
      err       <= 1'b0;
    end else begin
      seed_ld   <= 1'b0;
      pt_vld    <= 1'b0;
      ct_vld    <= 1'b0;
      msg_start <= 1'b0;
      msg_end   <= 1'b0;
      err       <= 1'b0;
      if (rx_data_rdy) begin
        unique case (r_state)
          ST_IDLE: begin
            r_cnt    <= '0;
            r_shadow <= '0;
            if (rx_data == CH_L) begin
              r_state <= ST_LOAD;
            end else if (rx_data == CH_E) begin
              r_state   <= ST_ENC;
              msg_start <= 1'b1;
            end else if (rx_data == CH_D) begin
              r_state   <= ST_DEC;
              msg_start <= 1'b1;
            end
          end
          ST_LOAD: begin
            if (rx_data == CH_CR) begin
              if (r_cnt == CNT_W'(8)) begin
                seed    <= r_shadow;
                seed_ld <= 1'b1;
              end else begin
                err <= 1'b1;
              end
              r_state <= ST_IDLE;
            end else if (!w_hex_ok || r_cnt == CNT_W'(8)) begin
              err     <= 1'b1;
              r_state <= ST_IDLE;
            end else begin
              r_shadow <= {r_shadow[27:0], w_nib};
              r_cnt    <= r_cnt + CNT_W'(1);
            end
          end
          ST_ENC: begin
            if (rx_data == CH_CR) begin
              msg_end <= 1'b1;
              r_state <= ST_IDLE;
            end else if (r_cnt == CNT_W'(MSG_MAX)) begin
              err     <= 1'b1;
              r_state <= ST_IDLE;
            end else begin
              pt_byte <= rx_data;
              pt_vld  <= 1'b1;
              r_cnt   <= r_cnt + CNT_W'(1);
            end
          end
          ST_DEC: begin
            if (rx_data == CH_CR) begin
              // An odd digit count leaves a dangling high nibble.
              if (r_cnt[0]) begin
                err <= 1'b1;
              end else begin
                msg_end <= 1'b1;
              end
              r_state <= ST_IDLE;
            end else if (!w_hex_ok || r_cnt == CNT_W'(MSG_MAX)) begin
              err     <= 1'b1;
              r_state <= ST_IDLE;
            end else begin
              if (!r_cnt[0]) begin
                r_hi <= w_nib;
              end else begin
                ct_byte <= {r_hi, w_nib};
                ct_vld  <= 1'b1;
              end
              r_cnt <= r_cnt + CNT_W'(1);
            end
          end
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

`ifdef CMD_ECHO_EN
  // Echo every received byte regardless of parser state.
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_data     <= '0;
      tx_data_rdy <= 1'b0;
    end else begin
      tx_data_rdy <= rx_data_rdy;
      if (rx_data_rdy) begin
        tx_data <= rx_data;
      end
    end
  end
`else
  assign tx_data     = 8'h00;
  assign tx_data_rdy = 1'b0;
`endif

endmodule

// File: tb/tb_lab4_cmd_parser.sv
// tb_lab4_cmd_parser: directed scenarios plus randomized command streams
// checked against a command-level reference model.
module tb_lab4_cmd_parser;

  localparam int MSG_MAX = 32;
  localparam int K_SEED = 0, K_PT = 1, K_CT = 2, K_START = 3, K_END = 4, K_ERR = 5, K_TX = 6;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_data_rdy = 1'b0;
  logic [31:0] seed;
  logic        seed_ld;
  logic [7:0]  pt_byte;
  logic        pt_vld;
  logic [7:0]  ct_byte;
  logic        ct_vld;
  logic        msg_start;
  logic        msg_end;
  logic [1:0]  mode;
  logic        err;
  logic [7:0]  tx_data;
  logic        tx_data_rdy;

  lab4_cmd_parser #(.MSG_MAX(MSG_MAX)) dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_data_rdy(rx_data_rdy),
    .seed(seed), .seed_ld(seed_ld), .pt_byte(pt_byte), .pt_vld(pt_vld),
    .ct_byte(ct_byte), .ct_vld(ct_vld), .msg_start(msg_start), .msg_end(msg_end),
    .mode(mode), .err(err), .tx_data(tx_data), .tx_data_rdy(tx_data_rdy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          kind;
    logic [31:0] val;
    int          edge_no;
  } evt_t;

  evt_t         obs[$];
  evt_t         exp_q[$];
  evt_t         tx_obs[$];
  byte unsigned s_bytes[$];
  int           s_edges[$];
  logic [31:0]  m_seed = 32'h0;
  int           edge_n = 0;
  bit           tx_nz = 1'b0;
  int           checks = 0;
  int           errors = 0;

  always @(posedge clk) edge_n <= edge_n + 1;

  function automatic evt_t mk(input int k, input logic [31:0] v, input int e);
    evt_t ev;
    ev.kind = k;
    ev.val = v;
    ev.edge_no = e;
    return ev;
  endfunction

  // Collect every output pulse with the index of the clock edge that produced it.
  always @(negedge clk) begin
    if (!rst) begin
      if (seed_ld)     obs.push_back(mk(K_SEED, seed, edge_n));
      if (pt_vld)      obs.push_back(mk(K_PT, {24'h0, pt_byte}, edge_n));
      if (ct_vld)      obs.push_back(mk(K_CT, {24'h0, ct_byte}, edge_n));
      if (msg_start)   obs.push_back(mk(K_START, 32'h0, edge_n));
      if (msg_end)     obs.push_back(mk(K_END, 32'h0, edge_n));
      if (err)         obs.push_back(mk(K_ERR, 32'h0, edge_n));
      if (tx_data_rdy) tx_obs.push_back(mk(K_TX, {24'h0, tx_data}, edge_n));
    end
    if (tx_data !== 8'h00 || tx_data_rdy !== 1'b0) tx_nz = 1'b1;
  end

  function automatic int count_kind(input int k);
    int n;
    n = 0;
    foreach (obs[i]) if (obs[i].kind == k) n++;
    return n;
  endfunction

  function automatic evt_t nth_kind(input int k, input int idx);
    int n;
    evt_t ev;
    n = 0;
    ev = mk(-1, 32'h0, -1);
    foreach (obs[i]) begin
      if (obs[i].kind == k) begin
        if (n == idx) ev = obs[i];
        n++;
      end
    end
    return ev;
  endfunction

  function automatic bit is_hex(input byte unsigned c);
    return (c >= "0" && c <= "9") || (c >= "a" && c <= "f") || (c >= "A" && c <= "F");
  endfunction

  function automatic int hex_val(input byte unsigned c);
    if (c <= "9") return int'(c) - int'("0");
    if (c >= "a") return int'(c) - int'("a") + 10;
    return int'(c) - int'("A") + 10;
  endfunction

  // Reference model: walks the byte stream one command at a time.
  task automatic model_run();
    int i;
    int n;
    byte unsigned c;
    byte unsigned d;
    logic [31:0] acc;
    int cnt;
    int hi;
    bit done;
    i = 0;
    n = s_bytes.size();
    exp_q.delete();
    while (i < n) begin
      c = s_bytes[i];
      i++;
      if (c == "L") begin
        acc = 32'h0;
        cnt = 0;
        done = 1'b0;
        while (!done && i < n) begin
          d = s_bytes[i];
          if (d == 8'h0D) begin
            if (cnt == 8) begin
              m_seed = acc;
              exp_q.push_back(mk(K_SEED, acc, s_edges[i]));
            end else begin
              exp_q.push_back(mk(K_ERR, 32'h0, s_edges[i]));
            end
            done = 1'b1;
          end else if (!is_hex(d) || cnt == 8) begin
            exp_q.push_back(mk(K_ERR, 32'h0, s_edges[i]));
            done = 1'b1;
          end else begin
            acc = acc * 16 + hex_val(d);
            cnt++;
          end
          i++;
        end
      end else if (c == "E" || c == "D") begin
        exp_q.push_back(mk(K_START, 32'h0, s_edges[i-1]));
        cnt = 0;
        hi = 0;
        done = 1'b0;
        while (!done && i < n) begin
          d = s_bytes[i];
          if (d == 8'h0D) begin
            if (c == "D" && (cnt % 2) == 1) exp_q.push_back(mk(K_ERR, 32'h0, s_edges[i]));
            else exp_q.push_back(mk(K_END, 32'h0, s_edges[i]));
            done = 1'b1;
          end else if ((c == "D" && !is_hex(d)) || cnt == MSG_MAX) begin
            exp_q.push_back(mk(K_ERR, 32'h0, s_edges[i]));
            done = 1'b1;
          end else begin
            if (c == "E") exp_q.push_back(mk(K_PT, {24'h0, d}, s_edges[i]));
            else if ((cnt % 2) == 0) hi = hex_val(d);
            else exp_q.push_back(mk(K_CT, 32'(hi * 16 + hex_val(d)), s_edges[i]));
            cnt++;
          end
          i++;
        end
      end
    end
  endtask

  task automatic put_byte(input byte unsigned b);
    @(posedge clk); #1;
    rx_data = b;
    rx_data_rdy = 1'b1;
    s_bytes.push_back(b);
    s_edges.push_back(edge_n + 1);
  endtask

  task automatic gap(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      rx_data_rdy = 1'b0;
    end
  endtask

  task automatic flush();
    gap(1);
    repeat (2) @(negedge clk);
  endtask

  task automatic send_str(input string s, input bit b2b);
    for (int i = 0; i < s.len(); i++) begin
      put_byte(s[i]);
      if (!b2b && $urandom_range(0, 1) == 1) gap($urandom_range(1, 2));
    end
  endtask

  task automatic start_run();
    obs.delete();
    tx_obs.delete();
    s_bytes.delete();
    s_edges.delete();
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    rx_data_rdy = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    rx_data_rdy = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({seed, pt_byte, ct_byte, tx_data} !== 56'h0) begin
      errors++;
      $display("FAIL reset_data: got seed=%h pt=%h ct=%h tx=%h, required all 0", seed, pt_byte, ct_byte, tx_data);
    end
    checks++;
    if ({seed_ld, pt_vld, ct_vld, msg_start, msg_end, err, tx_data_rdy} !== 7'h0) begin
      errors++;
      $display("FAIL reset_pulses: got %b, required 0000000",
               {seed_ld, pt_vld, ct_vld, msg_start, msg_end, err, tx_data_rdy});
    end
    checks++;
    if (mode !== 2'b00) begin
      errors++;
      $display("FAIL reset_mode: got %b, required 00", mode);
    end
    rst = 1'b0;
  endtask

  task automatic test_load();
    evt_t ev;
    start_run();
    put_byte("L");
    gap(1);
    checks++;
    if (mode !== 2'b01) begin
      errors++;
      $display("FAIL load_mode: got %b, required 01", mode);
    end
    send_str("12345678", 1'b0);
    put_byte(8'h0D);
    flush();
    checks++;
    if (seed !== 32'h12345678) begin
      errors++;
      $display("FAIL load_seed: got %h, required 12345678", seed);
    end
    checks++;
    if (count_kind(K_SEED) !== 1 || count_kind(K_ERR) !== 0) begin
      errors++;
      $display("FAIL load_pulses: got seed_ld=%0d err=%0d, required 1 and 0", count_kind(K_SEED), count_kind(K_ERR));
    end
    ev = nth_kind(K_SEED, 0);
    checks++;
    if (ev.edge_no !== s_edges[s_edges.size()-1]) begin
      errors++;
      $display("FAIL load_latency: seed_ld at edge %0d, required %0d", ev.edge_no, s_edges[s_edges.size()-1]);
    end
    checks++;
    if (mode !== 2'b00) begin
      errors++;
      $display("FAIL load_mode_end: got %b, required 00", mode);
    end
  endtask

  task automatic test_encrypt();
    byte unsigned want[5];
    evt_t ev;
    want = '{8'h61, 8'h62, 8'h63, 8'h64, 8'h21};
    start_run();
    put_byte("E");
    gap(1);
    checks++;
    if (mode !== 2'b10) begin
      errors++;
      $display("FAIL enc_mode: got %b, required 10", mode);
    end
    send_str("abcd!\r", 1'b0);
    flush();
    checks++;
    if (count_kind(K_START) !== 1 || count_kind(K_END) !== 1 || count_kind(K_PT) !== 5 || count_kind(K_ERR) !== 0) begin
      errors++;
      $display("FAIL enc_counts: got start=%0d end=%0d pt=%0d err=%0d, required 1 1 5 0",
               count_kind(K_START), count_kind(K_END), count_kind(K_PT), count_kind(K_ERR));
    end
    for (int i = 0; i < 5; i++) begin
      ev = nth_kind(K_PT, i);
      checks++;
      if (ev.val !== {24'h0, want[i]} || ev.edge_no !== s_edges[i+1]) begin
        errors++;
        $display("FAIL enc_pt[%0d]: got %h at edge %0d, required %h at edge %0d", i, ev.val, ev.edge_no, want[i], s_edges[i+1]);
      end
    end
    checks++;
    if (pt_byte !== 8'h21) begin
      errors++;
      $display("FAIL enc_hold: pt_byte got %h, required 21", pt_byte);
    end
  endtask

  task automatic test_decrypt();
    byte unsigned want[5];
    evt_t ev;
    want = '{8'hF0, 8'hC0, 8'h27, 8'h6C, 8'hB0};
    start_run();
    send_str("Df0c0276cb0\r", 1'b0);
    flush();
    checks++;
    if (count_kind(K_CT) !== 5 || count_kind(K_END) !== 1 || count_kind(K_ERR) !== 0) begin
      errors++;
      $display("FAIL dec_counts: got ct=%0d end=%0d err=%0d, required 5 1 0", count_kind(K_CT), count_kind(K_END), count_kind(K_ERR));
    end
    for (int i = 0; i < 5; i++) begin
      ev = nth_kind(K_CT, i);
      checks++;
      if (ev.val !== {24'h0, want[i]} || ev.edge_no !== s_edges[2*i+2]) begin
        errors++;
        $display("FAIL dec_ct[%0d]: got %h at edge %0d, required %h at edge %0d", i, ev.val, ev.edge_no, want[i], s_edges[2*i+2]);
      end
    end
  endtask

  task automatic test_errors();
    evt_t ev;
    start_run();
    send_str("L1234\rDabc\r", 1'b0);
    flush();
    checks++;
    if (count_kind(K_ERR) !== 2 || count_kind(K_SEED) !== 0 || count_kind(K_END) !== 0) begin
      errors++;
      $display("FAIL err_counts: got err=%0d seed_ld=%0d end=%0d, required 2 0 0", count_kind(K_ERR), count_kind(K_SEED), count_kind(K_END));
    end
    ev = nth_kind(K_ERR, 0);
    checks++;
    if (ev.edge_no !== s_edges[5]) begin
      errors++;
      $display("FAIL err_load_edge: got %0d, required %0d", ev.edge_no, s_edges[5]);
    end
    ev = nth_kind(K_CT, 0);
    checks++;
    if (count_kind(K_CT) !== 1 || ev.val !== 32'hAB) begin
      errors++;
      $display("FAIL err_ct: got %0d ct pulses first %h, required 1 of AB", count_kind(K_CT), ev.val);
    end
    checks++;
    if (seed !== 32'h12345678) begin
      errors++;
      $display("FAIL err_seed_kept: got %h, required 12345678", seed);
    end
  endtask

  task automatic test_overflow();
    string s;
    start_run();
    s = "E";
    for (int i = 0; i < MSG_MAX + 1; i++) s = {s, "x"};
    s = {s, "\r"};
    send_str(s, 1'b1);
    flush();
    checks++;
    if (count_kind(K_PT) !== MSG_MAX || count_kind(K_ERR) !== 1 || count_kind(K_END) !== 0) begin
      errors++;
      $display("FAIL ovf_enc: got pt=%0d err=%0d end=%0d, required %0d 1 0", count_kind(K_PT), count_kind(K_ERR), count_kind(K_END), MSG_MAX);
    end
    checks++;
    if (nth_kind(K_ERR, 0).edge_no !== s_edges[MSG_MAX+1]) begin
      errors++;
      $display("FAIL ovf_enc_edge: got %0d, required %0d", nth_kind(K_ERR, 0).edge_no, s_edges[MSG_MAX+1]);
    end
    start_run();
    s = "D";
    for (int i = 0; i < MSG_MAX + 2; i++) s = {s, "5"};
    s = {s, "\r"};
    send_str(s, 1'b1);
    flush();
    checks++;
    if (count_kind(K_CT) !== MSG_MAX / 2 || count_kind(K_ERR) !== 1 || count_kind(K_END) !== 0) begin
      errors++;
      $display("FAIL ovf_dec: got ct=%0d err=%0d end=%0d, required %0d 1 0", count_kind(K_CT), count_kind(K_ERR), count_kind(K_END), MSG_MAX / 2);
    end
  endtask

  task automatic test_reset_mid();
    start_run();
    put_byte("L");
    put_byte("1");
    put_byte("2");
    put_byte("3");
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    rx_data_rdy = 1'b0;
    checks++;
    if (seed !== 32'h0 || mode !== 2'b00) begin
      errors++;
      $display("FAIL rstmid_state: got seed=%h mode=%b, required 0 and 00", seed, mode);
    end
    s_bytes.delete();
    s_edges.delete();
    send_str("L00000000\r", 1'b1);
    flush();
    checks++;
    if (count_kind(K_ERR) !== 0 || count_kind(K_SEED) !== 1 || seed !== 32'h0) begin
      errors++;
      $display("FAIL rstmid_load: got err=%0d seed_ld=%0d seed=%h, required 0 1 0", count_kind(K_ERR), count_kind(K_SEED), seed);
    end
  endtask

  task automatic test_echo();
    start_run();
    send_str("E\r", 1'b0);
    flush();
`ifdef CMD_ECHO_EN
    checks++;
    if (tx_obs.size() !== 2) begin
      errors++;
      $display("FAIL echo_count: got %0d, required 2", tx_obs.size());
    end else begin
      checks++;
      if (tx_obs[0].val !== 32'h45 || tx_obs[0].edge_no !== s_edges[0] ||
          tx_obs[1].val !== 32'h0D || tx_obs[1].edge_no !== s_edges[1]) begin
        errors++;
        $display("FAIL echo_bytes: got %h@%0d %h@%0d, required 45@%0d 0d@%0d",
                 tx_obs[0].val, tx_obs[0].edge_no, tx_obs[1].val, tx_obs[1].edge_no, s_edges[0], s_edges[1]);
      end
    end
`else
    checks++;
    if (tx_obs.size() !== 0 || tx_nz !== 1'b0) begin
      errors++;
      $display("FAIL echo_off: got %0d tx pulses nonzero=%0b, required 0 and 0", tx_obs.size(), tx_nz);
    end
`endif
  endtask

  task automatic rand_byte(input byte unsigned b);
    put_byte(b);
    if ($urandom_range(0, 2) != 0) gap($urandom_range(1, 2));
  endtask

  task automatic test_random(input int ncmd);
    string hx;
    int r;
    int len;
    int bad;
    bit shown;
    hx = "0123456789abcdefABCDEF";
    do_reset();
    m_seed = 32'h0;
    start_run();
    for (int c = 0; c < ncmd; c++) begin
      r = $urandom_range(0, 9);
      if (r <= 2) begin
        len = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 10) : 8;
        bad = ($urandom_range(0, 5) == 0) ? $urandom_range(0, len) : -1;
        rand_byte("L");
        for (int k = 0; k < len; k++) rand_byte((k == bad) ? 8'h7A : hx[$urandom_range(0, 21)]);
        rand_byte(8'h0D);
      end else if (r <= 5) begin
        len = $urandom_range(0, MSG_MAX + 4);
        rand_byte("E");
        for (int k = 0; k < len; k++) rand_byte(8'($urandom_range(32, 126)));
        rand_byte(8'h0D);
      end else if (r <= 8) begin
        len = $urandom_range(0, MSG_MAX + 4);
        bad = ($urandom_range(0, 5) == 0) ? $urandom_range(0, len) : -1;
        rand_byte("D");
        for (int k = 0; k < len; k++) rand_byte((k == bad) ? 8'h67 : hx[$urandom_range(0, 21)]);
        rand_byte(8'h0D);
      end else begin
        rand_byte(8'($urandom_range(0, 255)));
      end
    end
    flush();
    model_run();
    checks++;
    if (obs.size() !== exp_q.size()) begin
      errors++;
      $display("FAIL rand_count: got %0d events, required %0d", obs.size(), exp_q.size());
    end
    shown = 1'b0;
    for (int k = 0; k < exp_q.size() && k < obs.size() && !shown; k++) begin
      checks++;
      if (obs[k].kind !== exp_q[k].kind || obs[k].val !== exp_q[k].val || obs[k].edge_no !== exp_q[k].edge_no) begin
        errors++;
        shown = 1'b1;
        $display("FAIL rand_evt[%0d]: got kind %0d val %h edge %0d, required kind %0d val %h edge %0d",
                 k, obs[k].kind, obs[k].val, obs[k].edge_no, exp_q[k].kind, exp_q[k].val, exp_q[k].edge_no);
      end
    end
    checks++;
    if (seed !== m_seed) begin
      errors++;
      $display("FAIL rand_seed: got %h, required %h", seed, m_seed);
    end
`ifdef CMD_ECHO_EN
    checks++;
    if (tx_obs.size() !== s_bytes.size()) begin
      errors++;
      $display("FAIL rand_echo: got %0d tx pulses, required %0d", tx_obs.size(), s_bytes.size());
    end
`else
    checks++;
    if (tx_obs.size() !== 0) begin
      errors++;
      $display("FAIL rand_echo_off: got %0d tx pulses, required 0", tx_obs.size());
    end
`endif
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_load();
    test_encrypt();
    test_decrypt();
    test_errors();
    test_overflow();
    test_reset_mid();
    test_echo();
    for (int it = 0; it < 3; it++) test_random(40);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/lab4_cmd_parser.md
LAB4_CMD_PARSER -- requirements
Module: lab4_cmd_parser

Interface
REQ-001 SHALL have parameter MSG_MAX, default 32, meaning the maximum payload bytes accepted per E or D command.
REQ-002 SHALL have port clk  input  1  the single system clock; all logic is on its rising edge.
REQ-003 SHALL have port rst  input  1  reset; synchronous and active-high.
REQ-004 SHALL have port rx_data  input  8  ASCII byte from the UART receiver.
REQ-005 SHALL have port rx_data_rdy  input  1  one-cycle strobe marking rx_data valid; may assert on consecutive cycles.
REQ-006 SHALL have port seed  output  32  last successfully loaded key/seed.
REQ-007 SHALL have port seed_ld  output  1  one-cycle pulse when seed updates.
REQ-008 SHALL have port pt_byte  output  8  plaintext byte (E mode).
REQ-009 SHALL have port pt_vld  output  1  one-cycle pulse qualifying pt_byte.
REQ-010 SHALL have port ct_byte  output  8  ciphertext byte assembled from two hex digits (D mode).
REQ-011 SHALL have port ct_vld  output  1  one-cycle pulse qualifying ct_byte.
REQ-012 SHALL have port msg_start  output  1  pulse on acceptance of an E or D command letter.
REQ-013 SHALL have port msg_end  output  1  pulse on a CR that terminates a valid E or D command.
REQ-014 SHALL have port mode  output  2  00 idle, 01 load, 10 encrypt, 11 decrypt; reflects the current state.
REQ-015 SHALL have port err  output  1  one-cycle pulse on any malformed command.
REQ-016 SHALL have port tx_data  output  8  echo byte to the UART transmitter.
REQ-017 SHALL have port tx_data_rdy  output  1  one-cycle pulse qualifying tx_data.

Function
REQ-018 SHALL be a four-state FSM: IDLE, LOAD, ENC, DEC; acts only on cycles where rx_data_rdy=1.
REQ-019 SHALL, from IDLE, go to LOAD on "L", to ENC on "E" (pulse msg_start), to DEC on "D" (pulse msg_start); all other bytes, including CR/LF, ignored.
REQ-020 SHALL treat 0-9, a-f and A-F as hex digits; every other byte is non-hex.
REQ-021 SHALL, in LOAD, shift each hex digit into a 32-bit shadow register MSB-first and count digits 0..8.
REQ-022 SHALL, in LOAD, on CR with count==8, copy shadow to seed, pulse seed_ld and return to IDLE.
REQ-023 SHALL, in LOAD, on CR with count!=8, a 9th digit, or a non-hex byte, pulse err, leave seed unchanged and return to IDLE.
REQ-024 SHALL, in ENC, present each non-CR byte on pt_byte with pt_vld pulse; on CR, pulse msg_end and return to IDLE.
REQ-025 SHALL, in DEC, store the first hex digit as the high nibble; the second completes ct_byte with ct_vld pulse.
REQ-026 SHALL, in DEC, on CR with an even digit count, pulse msg_end and return to IDLE; an odd count or non-hex byte pulses err, returns to IDLE, and emits no further ct_vld.
REQ-027 SHALL, in ENC or DEC, on a payload byte that would exceed MSG_MAX, pulse err, drop the byte, and return to IDLE without msg_end.
REQ-028 SHALL register all outputs; every pulse appears exactly one cycle after the causing rx_data_rdy.
REQ-029 SHALL keep pt_byte, ct_byte, seed and tx_data stable between their qualifying pulses.

Reset
REQ-030 SHALL, on rst=1 at a clock edge, enter IDLE, set seed, shadow, counters, pt_byte, ct_byte and tx_data to 0, and drive mode=00.
REQ-031 SHALL, on that edge, drive seed_ld, pt_vld, ct_vld, msg_start, msg_end, err and tx_data_rdy to 0.
REQ-032 SHALL give rst priority over a simultaneous rx_data_rdy; a partially received command is discarded with no err pulse.

Configuration
REQ-033 SHALL, when CMD_ECHO_EN is defined, copy every received byte to tx_data with a tx_data_rdy pulse one cycle after rx_data_rdy, in all states.
REQ-034 SHALL, when CMD_ECHO_EN is undefined, hold tx_data=0 and tx_data_rdy=0 and omit the echo logic.

Verification
REQ-035 Scenario: "L","1".."8",CR -> seed=32'h12345678 with one seed_ld pulse; mode=00 after the CR.
REQ-036 Scenario: "E","a","b","c","d","!",CR -> one msg_start; pt_vld x5 with pt_byte 61,62,63,64,21; one msg_end.
REQ-037 Scenario: "D","f0c0276cb0",CR -> ct_vld x5 with ct_byte F0,C0,27,6C,B0; one msg_end; no err.
REQ-038 Scenario: "L","1234",CR, then "D","abc",CR -> err pulse for each command; seed unchanged; one ct_vld (AB).
REQ-039 Scenario: rst asserted mid "L123" with back-to-back rx_data_rdy, then "L00000000",CR -> no err; seed=0 with seed_ld.
REQ-040 Scenario: with CMD_ECHO_EN defined, "E",CR -> tx_data 45 then 0D, each one cycle after its rx_data_rdy.
